// File: rtl/adar_spi_pkg.sv
// Shared types and frame-geometry constants for the ADAR-style SPI register slave.
package adar_spi_pkg;

    localparam int ADDR_WIDTH_DEF = 14;
    localparam int DATA_WIDTH_DEF = 8;

    // Frame layout with default widths: {R/W, reserved, address, data}, MSB first.
    localparam int FRAME_LEN = 2 + ADDR_WIDTH_DEF + DATA_WIDTH_DEF;
    localparam int RW_BIT    = FRAME_LEN - 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_DATA    = 3'd3,
        ST_DONE    = 3'd4
    } spi_state_e;

    function automatic int frame_len(input int addr_width, input int data_width);
        return 2 + addr_width + data_width;
    endfunction

endpackage

// File: rtl/adar_spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with single-cycle rise/fall pulses.
module adar_spi_sync_edge
    import adar_spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    // NOTE: non-blocking assignments keep meta -> sync -> prev a real three-stage pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/adar_spi_slave.sv
// SPI register-access slave: decodes {R/W, rsvd, addr, data} frames in the clk domain
// and issues single-cycle register read/write commands.
module adar_spi_slave
    import adar_spi_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  csb,
    input  logic                  mosi,
    input  logic [1:0]            spi_mode,
    output logic                  miso,
    output logic                  miso_oe,
    output logic                  reg_wr_valid,
    output logic                  reg_rd_req,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    input  logic                  reg_rd_valid,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  frame_err
);

    localparam int FLEN    = frame_len(ADDR_WIDTH, DATA_WIDTH);
    localparam int CMD_LEN = 2 + ADDR_WIDTH;
    localparam int CW      = $clog2(FLEN + 1);
    localparam int RXW     = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;

    localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_LEN - 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FLEN - 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic csb_s, csb_rise, csb_fall;
    logic mosi_meta, mosi_s;

    adar_spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .sync (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    adar_spi_sync_edge #(.RST_VAL(1'b1)) u_sync_csb (
        .clk  (clk),
        .rst  (rst),
        .din  (csb),
        .sync (csb_s),
        .rise (csb_rise),
        .fall (csb_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            mosi_meta <= mosi;
            mosi_s    <= mosi_meta;
        end
    end

    // An sclk edge is a sample edge when it lands on the level CPOL XNOR CPHA.
    logic sclk_edge, sample_lvl, sample_edge, shift_edge;
    assign sclk_edge   = sclk_rise | sclk_fall;
    assign sample_lvl  = (spi_mode[1] == spi_mode[0]);
    assign sample_edge = sclk_edge & (sclk_s == sample_lvl);
    assign shift_edge  = sclk_edge & (sclk_s != sample_lvl);

    assign miso_oe = ~csb_s;

    spi_state_e          state;
    logic [CW-1:0]       bit_cnt;
    logic [RXW-2:0]      rx_sr;
    logic [RXW-1:0]      rx_nxt;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic                is_read;
    logic                blocked;
    logic [1:0]          settle;

    assign rx_nxt = {rx_sr, mosi_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            rx_sr        <= '0;
            tx_sr        <= '0;
            is_read      <= 1'b0;
            blocked      <= 1'b1;
            settle       <= 2'd0;
            miso         <= 1'b0;
            reg_wr_valid <= 1'b0;
            reg_rd_req   <= 1'b0;
            reg_addr     <= '0;
            reg_wdata    <= '0;
            frame_err    <= 1'b0;
        end else begin
            reg_wr_valid <= 1'b0;
            reg_rd_req   <= 1'b0;
            frame_err    <= 1'b0;

            // After reset, wait for the synchronizer to settle and csb to read high
            // so a frame already in flight is never half-decoded.
            if (settle != 2'd3) settle <= settle + 2'd1;
            if (blocked && settle == 2'd3 && csb_s) blocked <= 1'b0;

            if (csb_fall && !blocked) begin
                state   <= ST_CMD;
                bit_cnt <= '0;
                rx_sr   <= '0;
                tx_sr   <= '0;
                is_read <= 1'b0;
                miso    <= 1'b0;
            end else if (csb_rise) begin
                if (state != ST_IDLE && state != ST_DONE) frame_err <= 1'b1;
                state <= ST_IDLE;
                miso  <= 1'b0;
            end else begin
                case (state)
                    ST_CMD: begin
                        if (sample_edge) begin
                            rx_sr   <= rx_nxt[RXW-2:0];
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == '0) is_read <= mosi_s;
                            if (bit_cnt == CMD_LAST) begin
                                reg_addr <= rx_nxt[ADDR_WIDTH-1:0];
                                if (is_read) begin
                                    reg_rd_req <= 1'b1;
                                    state      <= ST_RD_WAIT;
                                end else begin
                                    state <= ST_DATA;
                                end
                            end
                        end
                    end
                    ST_RD_WAIT: begin
                        if (reg_rd_valid) begin
                            tx_sr <= reg_rdata;
                            state <= ST_DATA;
                        end else if (shift_edge) begin
                            // Response missed the first data shift edge: send zeros.
                            tx_sr     <= '0;
                            miso      <= 1'b0;
                            frame_err <= 1'b1;
                            state     <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (shift_edge && is_read) begin
                            miso  <= tx_sr[DATA_WIDTH-1];
                            tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                        end
                        if (sample_edge) begin
                            rx_sr   <= rx_nxt[RXW-2:0];
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == FRAME_LAST) begin
                                if (!is_read) begin
                                    reg_wdata    <= rx_nxt[DATA_WIDTH-1:0];
                                    reg_wr_valid <= 1'b1;
                                end
                                miso  <= 1'b0;
                                state <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: miso <= 1'b0;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adar_spi_slave.sv
// Directed bench for adar_spi_slave: all four SPI modes, abort, missing read response, mid-frame reset.
module tb_adar_spi_slave;

    localparam int HP = 4;  // sclk half-period in clk cycles

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, csb, mosi;
    logic [1:0]  spi_mode;
    logic        miso, miso_oe;
    logic        reg_wr_valid, reg_rd_req;
    logic [13:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_rd_valid;
    logic [7:0]  reg_rdata;
    logic        frame_err;

    int n_cmp = 0;
    int n_bad = 0;

    int          wr_cnt, rd_cnt, err_cnt, both_cnt;
    logic [13:0] wr_addr, rd_addr;
    logic [7:0]  wr_data;
    logic        respond_en;

    adar_spi_slave dut (
        .clk          (clk),
        .rst          (rst),
        .sclk         (sclk),
        .csb          (csb),
        .mosi         (mosi),
        .spi_mode     (spi_mode),
        .miso         (miso),
        .miso_oe      (miso_oe),
        .reg_wr_valid (reg_wr_valid),
        .reg_rd_req   (reg_rd_req),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_rd_valid (reg_rd_valid),
        .reg_rdata    (reg_rdata),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    // Register-side model: answers a read request with 0xA5 on the next edge when enabled.
    always @(negedge clk) begin
        reg_rd_valid = reg_rd_req && respond_en;
        if (reg_wr_valid) begin
            wr_cnt++;
            wr_addr = reg_addr;
            wr_data = reg_wdata;
        end
        if (reg_rd_req) begin
            rd_cnt++;
            rd_addr = reg_addr;
        end
        if (frame_err) err_cnt++;
        if (reg_wr_valid && reg_rd_req) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        wr_cnt = 0; rd_cnt = 0; err_cnt = 0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        spi_mode = m;
        sclk     = m[1];
        wait_clk(10);
    endtask

    // Shifts the first nbits of word (MSB first) and returns what the master sampled on miso.
    task automatic spi_xfer(input logic [23:0] word, input int nbits, input bit end_frame,
                            output logic [23:0] rx);
        logic cpol, cpha;
        cpol = spi_mode[1];
        cpha = spi_mode[0];
        rx   = '0;
        csb  = 1'b0;
        wait_clk(HP);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi = word[23-i];
                wait_clk(HP);
                rx   = {rx[22:0], miso};
                sclk = ~cpol;
                wait_clk(HP);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = word[23-i];
                wait_clk(HP);
                rx   = {rx[22:0], miso};
                sclk = cpol;
                wait_clk(HP);
            end
        end
        wait_clk(HP);
        if (end_frame) begin
            csb  = 1'b1;
            mosi = 1'b0;
            wait_clk(12);
        end
    endtask

    logic [23:0] rx;

    initial begin
        rst = 1'b1; sclk = 1'b0; csb = 1'b1; mosi = 1'b0;
        spi_mode = 2'b00; reg_rdata = 8'hA5; respond_en = 1'b1;
        reg_rd_valid = 1'b0; both_cnt = 0;
        clear_counts();
        wait_clk(3);
        check("reset_outputs", {miso, miso_oe, reg_wr_valid, reg_rd_req, frame_err, reg_addr, reg_wdata}, '0);
        rst = 1'b0;
        wait_clk(10);

        for (int m = 0; m < 4; m++) begin
            set_mode(2'(m));
            clear_counts();
            spi_xfer(24'h003220, 24, 1'b1, rx);
            check($sformatf("m%0d_wr_cnt", m),   wr_cnt,  1);
            check($sformatf("m%0d_wr_addr", m),  wr_addr, 14'h0032);
            check($sformatf("m%0d_wr_data", m),  wr_data, 8'h20);
            check($sformatf("m%0d_wr_err", m),   err_cnt, 0);
            check($sformatf("m%0d_wr_miso", m),  rx,      0);
            check($sformatf("m%0d_oe_idle", m),  miso_oe, 1'b0);

            clear_counts();
            spi_xfer(24'h900500, 24, 1'b1, rx);
            check($sformatf("m%0d_rd_cnt", m),   rd_cnt,   1);
            check($sformatf("m%0d_rd_addr", m),  rd_addr,  14'h1005);
            check($sformatf("m%0d_rd_data", m),  rx[7:0],  8'hA5);
            check($sformatf("m%0d_rd_quiet", m), rx[23:8], 0);
            check($sformatf("m%0d_rd_nowr", m),  wr_cnt,   0);
            check($sformatf("m%0d_rd_err", m),   err_cnt,  0);
        end

        // Abort a write after 12 bits, then confirm a clean frame still decodes.
        set_mode(2'b00);
        clear_counts();
        spi_xfer(24'h003220, 12, 1'b1, rx);
        check("abort_no_wr", wr_cnt,  0);
        check("abort_err",   err_cnt, 1);
        clear_counts();
        spi_xfer(24'h0011C3, 24, 1'b1, rx);
        check("after_abort_wr",   wr_cnt,  1);
        check("after_abort_addr", wr_addr, 14'h0011);
        check("after_abort_data", wr_data, 8'hC3);
        check("after_abort_err",  err_cnt, 0);

        // Read with the register side silent.
        clear_counts();
        respond_en = 1'b0;
        spi_xfer(24'h900500, 24, 1'b1, rx);
        respond_en = 1'b1;
        check("noresp_rd_cnt", rd_cnt,  1);
        check("noresp_data",   rx[7:0], 8'h00);
        check("noresp_err",    err_cnt, 1);

        // Reset at bit 18 of a write, finish the frame while blocked, then a fresh frame.
        clear_counts();
        spi_xfer(24'h003220, 18, 1'b0, rx);
        rst = 1'b1;
        #1;
        check("midrst_outputs", {miso, miso_oe, reg_wr_valid, reg_rd_req, frame_err, reg_addr, reg_wdata}, '0);
        wait_clk(3);
        rst = 1'b0;
        spi_xfer(24'h003220, 6, 1'b1, rx);
        check("midrst_no_wr", wr_cnt,  0);
        check("midrst_no_err", err_cnt, 0);
        clear_counts();
        spi_xfer(24'h2ABC5A, 24, 1'b1, rx);
        check("post_rst_wr",   wr_cnt,  1);
        check("post_rst_addr", wr_addr, 14'h2ABC);
        check("post_rst_data", wr_data, 8'h5A);

        check("wr_rd_overlap", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adar_spi_slave.md
ADAR_SPI_SLAVE -- requirements
Module: adar_spi_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, register address width.
REQ-002 Parameter DATA_WIDTH, default 8, register data width; frame length FRAME_LEN = 2 + ADDR_WIDTH + DATA_WIDTH (24 by default).
REQ-003 Ports: clk  in  1  system clock, sole clock domain; all logic on rising edge.
REQ-004 Ports: rst  in  1  reset, asynchronous, active-high.
REQ-005 Ports: sclk, csb, mosi  in  1 each  SPI pins from the master, asynchronous to clk.
REQ-006 Ports: miso  out  1  serial read data; miso_oe  out  1  high while csb is low.
REQ-007 Ports: spi_mode  in  2  {CPOL, CPHA}; static while csb is low.
REQ-008 Ports: reg_wr_valid  out  1, reg_rd_req  out  1, reg_addr  out  ADDR_WIDTH, reg_wdata  out  DATA_WIDTH: register-side command.
REQ-009 Ports: reg_rd_valid  in  1, reg_rdata  in  DATA_WIDTH: register-side read response.
REQ-010 Ports: frame_err  out  1  one-cycle pulse on any aborted or malformed frame.

Function
REQ-011 sclk, csb and mosi SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized signals.
REQ-012 Frame format, MSB first: bit[FRAME_LEN-1] = R/W (1 = read); next bit reserved and ignored; then ADDR_WIDTH address bits; then DATA_WIDTH data bits.
REQ-013 Sample edge: rising sclk when CPOL == CPHA, otherwise falling sclk; the opposite edge is the shift edge.
REQ-014 FSM states: IDLE, CMD, RD_WAIT, DATA, DONE.
REQ-015 IDLE -> CMD on synchronized csb falling edge; bit_cnt cleared to 0, shift register cleared.
REQ-016 CMD: one bit per sample edge; after 2 + ADDR_WIDTH bits, latch reg_addr; on a read, pulse reg_rd_req for 1 cycle and enter RD_WAIT; on a write, enter DATA.
REQ-017 RD_WAIT: on reg_rd_valid, load reg_rdata into the tx shift register and enter DATA.
REQ-018 RD_WAIT: if the next shift edge arrives first, load 0x00, pulse frame_err, and enter DATA.
REQ-019 DATA, read: drive the tx MSB onto miso and shift on each shift edge; with CPHA=0 the first data bit SHALL also be present before the first data sample edge.
REQ-020 DATA, write: shift mosi in on sample edges; after DATA_WIDTH bits, pulse reg_wr_valid for 1 cycle with reg_addr/reg_wdata, no later than 2 clk after that sample edge.
REQ-021 After FRAME_LEN bits, enter DONE; ignore further sclk edges and hold miso at 0 until csb rises, then return to IDLE.
REQ-022 csb rising before FRAME_LEN bits SHALL abort: no reg_wr_valid, one frame_err pulse, return to IDLE.
REQ-023 csb falling while not in IDLE (glitch) SHALL restart the frame at bit 0.
REQ-024 miso SHALL be 0 outside the read data phase; miso_oe SHALL equal the inverted synchronized csb.
REQ-025 Timing: correct operation SHALL be guaranteed for sclk half-period >= 4 clk cycles (master prescale 4).
REQ-026 reg_wr_valid and reg_rd_req SHALL never be asserted in the same cycle; each is asserted at most once per frame.

Reset
REQ-027 On rst assertion, immediately: FSM = IDLE; bit_cnt = 0; shift registers = 0; miso = 0; miso_oe = 0; reg_wr_valid = reg_rd_req = frame_err = 0; reg_addr = reg_wdata = 0; synchronizer flops: csb = 1, sclk = 0, mosi = 0.
REQ-028 Reset mid-frame SHALL discard the frame with no register-side pulse; after reset release, a frame already in progress (csb low) SHALL be ignored until csb next rises.

Structure
REQ-029 Package adar_spi_pkg SHALL hold the FSM state enum, FRAME_LEN, and the R/W bit position constant.
REQ-030 Sub-module adar_spi_sync_edge: 2-flop synchronizer with rise/fall pulse outputs, instantiated for sclk and csb; mosi uses the synchronizer only.

Verification
REQ-031 Mode 0, write frame 0x003220 -> one reg_wr_valid pulse with reg_addr = 0x0032, reg_wdata = 0x20; frame_err = 0.
REQ-032 Mode 0, read frame 0x900500; register responds 0xA5 one cycle after reg_rd_req -> reg_addr = 0x1005; last 8 MISO bits = 0xA5.
REQ-033 Modes 1, 2 and 3: repeat both frames above -> identical register-side results and MISO data.
REQ-034 csb raised after 12 bits of a write -> no reg_wr_valid; exactly one frame_err pulse; next full frame works.
REQ-035 Read with reg_rd_valid withheld -> MISO data 0x00; frame_err pulses once.
REQ-036 rst asserted at bit 18 of a write -> all outputs zero immediately; no reg_wr_valid; a following frame after csb high is decoded correctly.
